ground_scroll_ctrl: RTL and testbench
=====================================

GROUND_SCROLL_CTRL -- requirements
Module: ground_scroll_ctrl

Interface
REQ-001 Parameter GROUND_TOP, default 416, SHALL set the first screen row of the ground band.
REQ-002 Parameter TRANSPARENT, default 8'hFF, SHALL set the bitmap colour treated as transparent.
REQ-003 Parameter ACCEL_FRAMES, default 64, SHALL set the number of frames between speed increments (GROUND_ACCEL_EN only).
REQ-004 The port list SHALL be, in order:
- clk  in  1  system clock; one clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at frame start.
- pixelX  in  11  current pixel column.
- pixelY  in  11  current pixel row.
- start  in  1  request to scroll (pulse).
- stop  in  1  request to halt (pulse).
- speed  in  6  scroll step in 1/16 px per frame.
- tile_colors  in  64x32x8  ground tile bitmap, [row][col][colour].
- drawingRequest  out  1  ground pixel is opaque.
- RGBout  out  8  ground pixel colour.
- scroll_px  out  5  current integer scroll offset.
- running  out  1  high in RUNNING and HALTING.

Function
REQ-005 The block SHALL hold a 9-bit offset accumulator: bits [8:4] integer pixels, bits [3:0] fraction; additions SHALL wrap modulo 512.
REQ-006 The FSM SHALL have states STOPPED, ARMED, RUNNING and HALTING.
REQ-007 start and stop SHALL each be latched into a sticky pending flag, cleared on the next startOfFrame.
REQ-008 If start and stop are pending together, stop SHALL win.
REQ-009 State changes SHALL occur only on startOfFrame; commands arriving in the same cycle as startOfFrame SHALL be honoured at that edge.
REQ-010 Transitions on startOfFrame SHALL be:
- STOPPED: to ARMED on start.
- ARMED: to RUNNING; to STOPPED on stop.
- RUNNING: to HALTING on stop.
- HALTING: to STOPPED; to RUNNING on start without stop.
REQ-011 On startOfFrame in RUNNING or HALTING, before the transition, offset SHALL add the effective speed; STOPPED and ARMED SHALL leave offset unchanged.
REQ-012 scroll_px SHALL equal offset[8:4] and SHALL change only in the cycle after startOfFrame.
REQ-013 The ground band SHALL be pixelY in [GROUND_TOP, GROUND_TOP+63] and pixelX in [0, 639].
REQ-014 Inside the band: row = pixelY-GROUND_TOP; col = (pixelX[4:0] + scroll_px) mod 32.
REQ-015 drawingRequest and RGBout SHALL be registered with 1-cycle latency from pixelX/pixelY.
REQ-016 drawingRequest SHALL be 1 only inside the band when the looked-up colour is not TRANSPARENT.
REQ-017 RGBout SHALL be the looked-up colour when drawingRequest is 1, otherwise TRANSPARENT.
REQ-018 The pixel path SHALL operate in all FSM states; a stopped ground is drawn unscrolled at its frozen offset.

Reset
REQ-019 reset SHALL force: state STOPPED, offset 0, pending flags 0, drawingRequest 0, RGBout TRANSPARENT, scroll_px 0, running 0, effective speed = speed.
REQ-020 reset asserted mid-frame or mid-scroll SHALL take effect at the next edge and override startOfFrame and commands in the same cycle.

Configuration
REQ-021 With GROUND_ACCEL_EN defined, the effective speed SHALL load from speed on entry to RUNNING from ARMED.
REQ-022 With GROUND_ACCEL_EN defined, the effective speed SHALL increment by 1 every ACCEL_FRAMES frames spent in RUNNING, saturating at 63.
REQ-023 Without GROUND_ACCEL_EN, the effective speed SHALL equal the speed input sampled at each startOfFrame, and no frame counter SHALL exist.

Structure
REQ-024 Package ground_pkg SHALL hold: the state enum, OFFSET_W=9, FRAC_W=4, TILE_H=64, TILE_W=32, and the default TRANSPARENT.
REQ-025 The accumulator, its wrap and the GROUND_ACCEL_EN speed logic SHALL live in sub-module ground_offset_acc; the FSM and pixel path SHALL stay in ground_scroll_ctrl.

Verification
REQ-026 Reset, then start and three startOfFrame pulses with speed=16 -> ARMED after frame 1, RUNNING after frame 2, scroll_px=1 after frame 3.
REQ-027 speed=40 in RUNNING for 13 frames -> offset=520 mod 512=8, scroll_px=0; wrap shows no glitch.
REQ-028 start and stop in the same cycle as startOfFrame while RUNNING -> HALTING; one more advance; then STOPPED with running=0.
REQ-029 scroll_px=3, pixel (5, GROUND_TOP+4) -> one cycle later RGBout=tile_colors[4][8]=8'h79, drawingRequest=1.
REQ-030 Pixel at row GROUND_TOP-1, and pixels whose colour is 8'hFF -> drawingRequest=0, RGBout=8'hFF.
REQ-031 GROUND_ACCEL_EN with ACCEL_FRAMES=4 and speed=62 -> effective speed 63 after 4 RUNNING frames and stays 63; reset mid-run -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/ground_pkg.sv
// ground_pkg -- shared types and constants for the scrolling ground band.
//
// Contents:
//   ground_state_e      scroll FSM states
//   OFFSET_W / FRAC_W   offset accumulator width and its fractional bits
//   TILE_H / TILE_W     ground tile bitmap size in pixels
//   SPEED_W             width of the speed value (1/16 px per frame)
//   TRANSPARENT_DEFAULT bitmap colour that means "no pixel here"
package ground_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2,
        ST_HALTING = 2'd3
    } ground_state_e;

    localparam int OFFSET_W = 9;
    localparam int FRAC_W   = 4;
    localparam int INT_W    = OFFSET_W - FRAC_W;
    localparam int TILE_H   = 64;
    localparam int TILE_W   = 32;
    localparam int SPEED_W  = 6;

    localparam logic [7:0] TRANSPARENT_DEFAULT = 8'hFF;

endpackage

// File: rtl/ground_offset_acc.sv
// ground_offset_acc -- fixed-point scroll offset accumulator.
//
// The offset is OFFSET_W bits with FRAC_W fractional bits and wraps
// modulo 2**OFFSET_W. Only the integer part leaves this block.
//
// Optional feature (macro GROUND_ACCEL_EN): the effective speed is loaded
// from speed_i on load_i and grows by one every ACCEL_FRAMES counted frames,
// saturating at the all-ones speed. Without the macro the effective speed is
// simply speed_i at the advancing frame edge.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   advance_i      frame edge where the offset must add the effective speed
//   load_i         frame edge entering RUNNING from ARMED (accel build only)
//   count_i        frame edge spent in RUNNING (accel build only)
//   speed_i        requested speed, 1/16 px per frame
//   scroll_px_o    integer part of the offset
module ground_offset_acc
    import ground_pkg::*;
#(
    parameter int ACCEL_FRAMES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance_i,
    input  logic               load_i,
    input  logic               count_i,
    input  logic [SPEED_W-1:0] speed_i,
    output logic [INT_W-1:0]   scroll_px_o
);

    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [SPEED_W-1:0]  eff_speed;

`ifdef GROUND_ACCEL_EN
    localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [SPEED_W-1:0] eff_speed_q, eff_speed_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        eff_speed_d = eff_speed_q;
        if (load_i) begin
            eff_speed_d = speed_i;
            frame_cnt_d = '0;
        end else if (count_i) begin
            if (frame_cnt_q == CNT_W'(ACCEL_FRAMES - 1)) begin
                frame_cnt_d = '0;
                if (eff_speed_q != '1) begin
                    eff_speed_d = eff_speed_q + 1'b1;
                end
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            eff_speed_q <= speed_i;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            eff_speed_q <= eff_speed_d;
        end
    end

    assign eff_speed = eff_speed_q;
`else
    localparam int unused_accel_frames = ACCEL_FRAMES;
    logic unused_accel;

    assign eff_speed    = speed_i;
    assign unused_accel = ^{load_i, count_i};
`endif

    // Plain binary add: the carry out of the top bit is the modulo wrap.
    always_comb begin
        offset_d = offset_q;
        if (advance_i) begin
            offset_d = offset_q + OFFSET_W'(eff_speed);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end

    assign scroll_px_o = offset_q[OFFSET_W-1:FRAC_W];

endmodule

// File: rtl/ground_scroll_ctrl.sv
// ground_scroll_ctrl -- scrolling ground band: scroll FSM plus pixel lookup.
//
// Handshake: start/stop are single-cycle pulses with no ready; each is held
// in a sticky pending flag until the next startOfFrame, where the FSM acts on
// the pending flags OR'd with any pulse arriving in that very cycle (stop
// wins over start), then clears them. The pixel output is valid every cycle,
// one cycle after pixelX/pixelY.
//
// Optional feature: define GROUND_ACCEL_EN for the self-accelerating speed
// (handled in ground_offset_acc).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   startOfFrame               one-cycle frame-start pulse
//   pixelX, pixelY             current raster position
//   start, stop                scroll requests (pulses)
//   speed                      scroll step, 1/16 px per frame
//   tile_colors                64x32 ground bitmap, [row][col][colour]
//   drawingRequest, RGBout     registered ground pixel
//   scroll_px                  integer scroll offset
//   running                    high in RUNNING and HALTING
module ground_scroll_ctrl
    import ground_pkg::*;
#(
    parameter int         GROUND_TOP   = 416,
    parameter logic [7:0] TRANSPARENT  = TRANSPARENT_DEFAULT,
    parameter int         ACCEL_FRAMES = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                startOfFrame,
    input  logic [10:0]                         pixelX,
    input  logic [10:0]                         pixelY,
    input  logic                                start,
    input  logic                                stop,
    input  logic [SPEED_W-1:0]                  speed,
    input  logic [TILE_H-1:0][TILE_W-1:0][7:0]  tile_colors,
    output logic                                drawingRequest,
    output logic [7:0]                          RGBout,
    output logic [INT_W-1:0]                    scroll_px,
    output logic                                running
);

    localparam logic [10:0] BAND_TOP = 11'(GROUND_TOP);
    localparam logic [10:0] BAND_BOT = 11'(GROUND_TOP + TILE_H - 1);
    localparam logic [10:0] X_LAST   = 11'd639;

    ground_state_e state_q, state_d;
    logic          start_pend_q, stop_pend_q;
    logic          start_now, stop_now;
    logic          advance, load, count;

    // ---------------- scroll FSM ----------------
    always_comb begin
        state_d   = state_q;
        start_now = start_pend_q | start;
        stop_now  = stop_pend_q | stop;
        if (startOfFrame) begin
            case (state_q)
                ST_STOPPED: if (start_now && !stop_now) state_d = ST_ARMED;
                ST_ARMED:   state_d = stop_now ? ST_STOPPED : ST_RUNNING;
                ST_RUNNING: if (stop_now) state_d = ST_HALTING;
                ST_HALTING: state_d = (start_now && !stop_now) ? ST_RUNNING : ST_STOPPED;
                default:    state_d = ST_STOPPED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_STOPPED;
            start_pend_q <= 1'b0;
            stop_pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (startOfFrame) begin
                start_pend_q <= 1'b0;
                stop_pend_q  <= 1'b0;
            end else begin
                start_pend_q <= start_pend_q | start;
                stop_pend_q  <= stop_pend_q | stop;
            end
        end
    end

    assign running = (state_q == ST_RUNNING) || (state_q == ST_HALTING);
    // The offset advances using the state held before this frame's transition.
    assign advance = startOfFrame && running;
    assign load    = startOfFrame && (state_q == ST_ARMED) && (state_d == ST_RUNNING);
    assign count   = startOfFrame && (state_q == ST_RUNNING);

    ground_offset_acc #(
        .ACCEL_FRAMES (ACCEL_FRAMES)
    ) u_acc (
        .clk         (clk),
        .reset       (reset),
        .advance_i   (advance),
        .load_i      (load),
        .count_i     (count),
        .speed_i     (speed),
        .scroll_px_o (scroll_px)
    );

    // ---------------- pixel path ----------------
    logic       in_band;
    logic [5:0] row;
    logic [4:0] col;
    logic [7:0] color;
    logic       drawing_d, drawing_q;
    logic [7:0] rgb_d, rgb_q;

    always_comb begin
        in_band   = (pixelY >= BAND_TOP) && (pixelY <= BAND_BOT) && (pixelX <= X_LAST);
        // Only the low six bits of the row difference matter inside the band.
        row       = pixelY[5:0] - BAND_TOP[5:0];
        col       = pixelX[4:0] + scroll_px;
        color     = tile_colors[row][col];
        drawing_d = in_band && (color != TRANSPARENT);
        rgb_d     = drawing_d ? color : TRANSPARENT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drawing_q <= 1'b0;
            rgb_q     <= TRANSPARENT;
        end else begin
            drawing_q <= drawing_d;
            rgb_q     <= rgb_d;
        end
    end

    assign drawingRequest = drawing_q;
    assign RGBout         = rgb_q;

endmodule

// File: tb/tb_ground_scroll_ctrl.sv
module tb_ground_scroll_ctrl;

    localparam int GT  = 416;
    localparam int ACC = 4;
    localparam int M_STOP = 0, M_ARM = 1, M_RUN = 2, M_HALT = 3;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [5:0]  speed = '0;
    logic [63:0][31:0][7:0] tiles;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic [4:0]  scroll_px;
    logic        running;

    always #5 clk = ~clk;

    ground_scroll_ctrl #(
        .ACCEL_FRAMES (ACC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .start          (start),
        .stop           (stop),
        .speed          (speed),
        .tile_colors    (tiles),
        .drawingRequest (drawingRequest),
        .RGBout         (RGBout),
        .scroll_px      (scroll_px),
        .running        (running)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [8:0]  exp_q[$];      // {drawingRequest, RGBout}
    logic [5:0]  frame_q[$];    // {running, scroll_px}
    logic        pix_req = 1'b0;
    logic        sof_req = 1'b0;

    // ---------------- reference model ----------------
    int m_mode, m_off, m_eff, m_cnt;
    bit m_spend, m_ppend;

    function automatic int m_scroll();
        return m_off / 16;
    endfunction

    function automatic logic [8:0] model_pixel(input int x, input int y);
        int r, c;
        logic [7:0] colr;
        if (y >= GT && y < GT + 64 && x < 640) begin
            r = y - GT;
            c = ((x % 32) + m_scroll()) % 32;
            colr = tiles[r][c];
            if (colr != 8'hFF) return {1'b1, colr};
        end
        return {1'b0, 8'hFF};
    endfunction

    task automatic model_frame(input bit st, input bit sp, input int spd);
        bit s, p;
        int step, nxt;
        s = m_spend || st;
        p = m_ppend || sp;
        m_spend = 0;
        m_ppend = 0;
`ifdef GROUND_ACCEL_EN
        step = m_eff;
`else
        step = spd;
`endif
        if (m_mode == M_RUN || m_mode == M_HALT) m_off = (m_off + step) % 512;
`ifdef GROUND_ACCEL_EN
        if (m_mode == M_RUN) begin
            m_cnt++;
            if (m_cnt == ACC) begin
                m_cnt = 0;
                if (m_eff < 63) m_eff++;
            end
        end
`endif
        nxt = m_mode;
        case (m_mode)
            M_STOP: if (s && !p) nxt = M_ARM;
            M_ARM:  nxt = p ? M_STOP : M_RUN;
            M_RUN:  if (p) nxt = M_HALT;
            default: nxt = (s && !p) ? M_RUN : M_STOP;
        endcase
        if (m_mode == M_ARM && nxt == M_RUN) begin
            m_eff = spd;
            m_cnt = 0;
        end
        m_mode = nxt;
    endtask

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic       mon_r, mon_p, mon_f;
    logic [4:0] cur_scroll = '0;
    logic       cur_run = 1'b0;
    logic [8:0] pe;
    logic [5:0] fe;

    always @(posedge clk) begin
        mon_r = reset;
        mon_p = pix_req;
        mon_f = sof_req;
        #1;
        if (mon_r) begin
            cur_scroll = '0;
            cur_run    = 1'b0;
            chk("reset_scroll_px", 32'(scroll_px), 0);
            chk("reset_running", 32'(running), 0);
            chk("reset_drawingRequest", 32'(drawingRequest), 0);
            chk("reset_RGBout", 32'(RGBout), 32'hFF);
        end else begin
            if (mon_f) begin
                if (frame_q.size() == 0) begin
                    chk("frame_queue_empty", 1, 0);
                end else begin
                    fe = frame_q.pop_front();
                    cur_run    = fe[5];
                    cur_scroll = fe[4:0];
                end
            end
            chk("scroll_px", 32'(scroll_px), 32'(cur_scroll));
            chk("running", 32'(running), 32'(cur_run));
            if (mon_p) begin
                if (exp_q.size() == 0) begin
                    chk("pixel_queue_empty", 1, 0);
                end else begin
                    pe = exp_q.pop_front();
                    chk("drawingRequest", 32'(drawingRequest), 32'(pe[8]));
                    chk("RGBout", 32'(RGBout), 32'(pe[7:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit sof, input bit st, input bit sp, input int spd,
                       input int x, input int y, input bit pix);
        @(negedge clk);
        startOfFrame = sof;
        start   = st;
        stop    = sp;
        speed   = 6'(spd);
        pixelX  = 11'(x);
        pixelY  = 11'(y);
        pix_req = pix;
        sof_req = sof;
        if (pix) exp_q.push_back(model_pixel(x, y));
        if (sof) begin
            model_frame(st, sp, spd);
            frame_q.push_back({(m_mode == M_RUN || m_mode == M_HALT) ? 1'b1 : 1'b0, 5'(m_scroll())});
        end else begin
            m_spend = m_spend || st;
            m_ppend = m_ppend || sp;
        end
    endtask

    task automatic frame(input bit st, input bit sp, input int spd);
        cyc(1, st, sp, spd, $urandom_range(0, 700), $urandom_range(400, 490), 1);
    endtask

    task automatic idle(input int spd);
        cyc(0, 0, 0, spd, $urandom_range(0, 700), $urandom_range(400, 490), 1);
    endtask

    // Reset asserted together with a frame pulse and both commands.
    task automatic do_reset(input int spd);
        @(negedge clk);
        reset = 1'b1;
        startOfFrame = 1'b1;
        start = 1'b1;
        stop = 1'b1;
        speed = 6'(spd);
        pix_req = 1'b0;
        sof_req = 1'b0;
        m_mode = M_STOP;
        m_off = 0;
        m_spend = 0;
        m_ppend = 0;
        m_eff = spd;
        m_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        startOfFrame = 1'b0;
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic direct(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, act, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 32; c++)
                tiles[r][c] = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        tiles[4][8]  = 8'h79;
        tiles[10][0] = 8'hFF;
        m_mode = M_STOP; m_off = 0; m_eff = 0; m_cnt = 0; m_spend = 0; m_ppend = 0;

        do_reset(16);

        // start pulse, then three frames at speed 16
        cyc(0, 1, 0, 16, 0, 0, 0);
        idle(16);
        frame(0, 0, 16);
        @(posedge clk); #2;
        direct("armed_running", 32'(running), 0);
        frame(0, 0, 16);
        @(posedge clk); #2;
        direct("run_running", 32'(running), 1);
        direct("run_scroll0", 32'(scroll_px), 0);
        frame(0, 0, 16);
        @(posedge clk); #2;
        direct("first_advance_scroll", 32'(scroll_px), 1);

        // wrap: 13 frames at speed 40 from offset 0
        do_reset(40);
        cyc(0, 1, 0, 40, 0, 0, 0);
        frame(0, 0, 40);
        frame(0, 0, 40);
        for (int f = 0; f < 13; f++) begin
            frame(0, 0, 40);
            for (int k = 0; k < 3; k++) idle(40);
        end
        @(posedge clk); #2;
        direct("wrap_scroll", 32'(scroll_px), 0);

        // start+stop with the frame pulse while RUNNING
        frame(1, 1, 40);
        idle(40);
        frame(0, 0, 40);
        @(posedge clk); #2;
        direct("halt_to_stopped", 32'(running), 0);

        // pixel lookups at scroll 3
        do_reset(48);
        cyc(0, 1, 0, 48, 0, 0, 0);
        frame(0, 0, 48);
        frame(0, 0, 48);
        frame(0, 0, 48);
        cyc(0, 0, 0, 48, 5, GT + 4, 1);
        @(posedge clk); #2;
        direct("tile_4_8_rgb", 32'(RGBout), 32'h79);
        direct("tile_4_8_dr", 32'(drawingRequest), 1);
        cyc(0, 0, 0, 48, 5, GT - 1, 1);
        cyc(0, 0, 0, 48, 29, GT + 10, 1);
        cyc(0, 0, 0, 48, 640, GT + 4, 1);
        cyc(0, 0, 0, 48, 639, GT + 63, 1);
        cyc(0, 0, 0, 48, 0, GT + 64, 1);

`ifdef GROUND_ACCEL_EN
        // saturating acceleration from 62
        do_reset(62);
        cyc(0, 1, 0, 62, 0, 0, 0);
        frame(0, 0, 62);
        frame(0, 0, 62);
        for (int f = 0; f < 12; f++) frame(0, 0, $urandom_range(0, 63));
        do_reset($urandom_range(0, 63));
        idle(0);
`endif

        // randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(0, 63));
            end else begin
                cyc($urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 63),
                    $urandom_range(0, 700), $urandom_range(400, 490), 1);
            end
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("pixel_queue_drained", 32'(exp_q.size()), 0);
        chk("frame_queue_drained", 32'(frame_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
